// File: rtl/fetch_if.sv
// fetch_if: handshake/bus bundle between the fetch unit and its controller.
//   master : drives load/run/stall/redirect controls, observes fetch outputs
//   slave  : fetch_unit side
// Signals:
//   load_en, load_valid, load_data : program-load controls and data
//   run, stall, redirect, redirect_pc : execute controls
//   pc, instr, instr_pc, instr_valid : fetch outputs
//   load_count, load_full, halted, trap : status
interface fetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic            load_en;
  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            run;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic [AW:0]     load_count;
  logic            load_full;
  logic            halted;
  logic            trap;

  modport master (
    output load_en, load_valid, load_data, run, stall, redirect, redirect_pc,
    input  pc, instr, instr_pc, instr_valid, load_count, load_full, halted, trap
  );

  modport slave (
    input  load_en, load_valid, load_data, run, stall, redirect, redirect_pc,
    output pc, instr, instr_pc, instr_valid, load_count, load_full, halted, trap
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction memory, program counter and IDLE/LOAD/RUN/HALT
// control for the RV32I core.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : fetch_if.slave (load controls, run/stall/redirect, fetch outputs,
//          load status, halted/trap)
// Parameters: XLEN word width, DEPTH memory words (power of 2, >= 2),
// RESET_PC start address (4-byte aligned).
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [XLEN-1:0] EBREAK  = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t state, state_next;

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            instr_valid_q;
  logic [AW:0]     load_count_q;
  logic            trap_q;

  logic misaligned;
  logic ebreak_hit;
  logic enter_load;
  logic mem_we;

  always_comb begin
    misaligned = |bus.redirect_pc[1:0];
    ebreak_hit = instr_valid_q && (instr_q == EBREAK);
    enter_load = (state_next == LOAD) && (state != LOAD);
    mem_we     = (state == LOAD) && bus.load_valid && (load_count_q != FULL);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: redirect outranks stall, stall outranks EBREAK
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.load_en)  state_next = LOAD;
        else if (bus.run) state_next = RUN;
      end
      LOAD: begin
        if (!bus.load_en) state_next = IDLE;
      end
      RUN: begin
        if (!bus.run)                     state_next = IDLE;
        else if (bus.redirect)            state_next = misaligned ? HALT : RUN;
        else if (!bus.stall && ebreak_hit) state_next = HALT;
      end
      HALT: begin
        if (bus.load_en) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.pc          = pc_q;
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.instr_valid = instr_valid_q;
    bus.load_count  = load_count_q;
    bus.load_full   = (load_count_q == FULL);
    bus.halted      = (state == HALT);
    bus.trap        = trap_q;
  end

  // Instruction memory: not reset, so a loaded program survives reset
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[load_count_q[AW-1:0]] <= bus.load_data;
  end

  // Fetch datapath and load counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      load_count_q  <= '0;
      trap_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (enter_load) begin
            pc_q          <= RESET_PC;
            load_count_q  <= '0;
            trap_q        <= 1'b0;
            instr_valid_q <= 1'b0;
          end
        end
        LOAD: begin
          if (mem_we) load_count_q <= load_count_q + CNT_ONE;
        end
        RUN: begin
          if (!bus.run) begin
            instr_valid_q <= 1'b0;
          end else if (bus.redirect) begin
            // Squash; a misaligned target traps and leaves pc untouched
            instr_valid_q <= 1'b0;
            if (misaligned) trap_q <= 1'b1;
            else            pc_q   <= bus.redirect_pc;
          end else if (bus.stall) begin
            // hold everything
          end else if (ebreak_hit) begin
            instr_valid_q <= 1'b0;
          end else begin
            instr_q       <= mem[pc_q[AW+1:2]];
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + PC_STEP;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_if #(.XLEN(32), .DEPTH(32)) bus ();
  fetch_if #(.XLEN(32), .DEPTH(8))  b8 ();

  fetch_unit #(.XLEN(32), .DEPTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fetch_unit #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  logic [31:0] prog1 [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00100073};
  logic [31:0] prog2 [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193,
                             32'h00400213, 32'h00500293, 32'h00600313, 32'h00700393};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load_en = 0; bus.load_valid = 0; bus.load_data = '0; bus.run = 0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    b8.load_en = 0; b8.load_valid = 0; b8.load_data = '0; b8.run = 0;
    b8.stall = 0; b8.redirect = 0; b8.redirect_pc = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    step(); step();
    tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
    tests++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin fails++; $display("FAIL reset_instr got %h/%h exp 0/0", bus.instr, bus.instr_pc); end
    tests++; if ({bus.instr_valid, bus.load_full, bus.halted, bus.trap} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {bus.instr_valid, bus.load_full, bus.halted, bus.trap}); end
    tests++; if (bus.load_count !== 6'd0 || b8.load_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d/%0d exp 0/0", bus.load_count, b8.load_count); end
    rst = 1;
    step();
  endtask

  task automatic test_load_run();
    bus.load_en = 1; step();
    bus.load_valid = 1;
    for (int i = 0; i < 4; i++) begin bus.load_data = prog1[i]; step(); end
    tests++; if (bus.load_count !== 6'd4 || bus.load_full !== 1'b0) begin fails++; $display("FAIL load4_count got %0d full %b exp 4 full 0", bus.load_count, bus.load_full); end
    bus.load_valid = 0; bus.load_en = 0; step();
    bus.run = 1; step();
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (bus.instr_pc !== 32'(i * 4) || bus.instr !== prog1[i] || bus.instr_valid !== 1'b1) begin
        fails++; $display("FAIL run_seq[%0d] got pc %h instr %h v %b exp pc %h instr %h v 1", i, bus.instr_pc, bus.instr, bus.instr_valid, 32'(i * 4), prog1[i]);
      end
    end
    step();
    tests++; if (bus.halted !== 1'b1 || bus.trap !== 1'b0 || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL ebreak_halt got h %b t %b v %b exp h 1 t 0 v 0", bus.halted, bus.trap, bus.instr_valid); end
    tests++; if (bus.pc !== 32'h10) begin fails++; $display("FAIL ebreak_pc got %h exp %h", bus.pc, 32'h10); end
    step();
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_hold_run got %b exp 1", bus.halted); end
  endtask

  task automatic test_stall_redirect();
    bus.run = 0; bus.load_en = 1; step();
    tests++; if (bus.halted !== 1'b0 || bus.pc !== 32'h0 || bus.load_count !== 6'd0) begin fails++; $display("FAIL reload_entry got h %b pc %h cnt %0d exp h 0 pc 0 cnt 0", bus.halted, bus.pc, bus.load_count); end
    bus.load_valid = 1;
    for (int i = 0; i < 8; i++) begin bus.load_data = prog2[i]; step(); end
    bus.load_valid = 0; bus.load_en = 0; step();
    bus.run = 1; step();
    step(); step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.pc !== 32'h8 || bus.instr_pc !== 32'h4 || bus.instr !== prog2[1] || bus.instr_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d] got pc %h ipc %h instr %h v %b exp pc 8 ipc 4 instr %h v 1", i, bus.pc, bus.instr_pc, bus.instr, bus.instr_valid, prog2[1]);
      end
    end
    bus.stall = 0; step();
    tests++; if (bus.instr_pc !== 32'h8 || bus.instr !== prog2[2]) begin fails++; $display("FAIL stall_resume0 got %h/%h exp 8/%h", bus.instr_pc, bus.instr, prog2[2]); end
    step();
    tests++; if (bus.instr_pc !== 32'hC || bus.instr !== prog2[3]) begin fails++; $display("FAIL stall_resume1 got %h/%h exp c/%h", bus.instr_pc, bus.instr, prog2[3]); end
    bus.redirect = 1; bus.redirect_pc = 32'h10; bus.stall = 1; step();
    tests++; if (bus.instr_valid !== 1'b0 || bus.pc !== 32'h10) begin fails++; $display("FAIL redirect_bubble got v %b pc %h exp v 0 pc 10", bus.instr_valid, bus.pc); end
    bus.redirect = 0; bus.stall = 0; step();
    tests++; if (bus.instr_pc !== 32'h10 || bus.instr !== prog2[4] || bus.instr_valid !== 1'b1) begin fails++; $display("FAIL redirect_target got ipc %h instr %h v %b exp 10/%h/1", bus.instr_pc, bus.instr, bus.instr_valid, prog2[4]); end
  endtask

  task automatic test_misaligned();
    bus.redirect = 1; bus.redirect_pc = 32'h6; step();
    bus.redirect = 0;
    tests++; if (bus.halted !== 1'b1 || bus.trap !== 1'b1) begin fails++; $display("FAIL misalign_trap got h %b t %b exp 1 1", bus.halted, bus.trap); end
    tests++; if (bus.pc !== 32'h14 || bus.instr_valid !== 1'b0 || bus.instr_pc !== 32'h10) begin fails++; $display("FAIL misalign_pc got pc %h v %b ipc %h exp 14 0 10", bus.pc, bus.instr_valid, bus.instr_pc); end
    step();
    tests++; if (bus.halted !== 1'b1 || bus.pc !== 32'h14) begin fails++; $display("FAIL misalign_run_ignored got h %b pc %h exp 1 14", bus.halted, bus.pc); end
    bus.run = 0; bus.load_en = 1; step();
    tests++; if (bus.halted !== 1'b0 || bus.trap !== 1'b0 || bus.pc !== 32'h0) begin fails++; $display("FAIL misalign_reload got h %b t %b pc %h exp 0 0 0", bus.halted, bus.trap, bus.pc); end
  endtask

  task automatic test_reset_mid_load();
    bus.load_valid = 1;
    for (int i = 0; i < 3; i++) begin bus.load_data = prog2[i]; step(); end
    tests++; if (bus.load_count !== 6'd3) begin fails++; $display("FAIL midload_count got %0d exp 3", bus.load_count); end
    rst = 0; step();
    tests++; if (bus.load_count !== 6'd0 || bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin fails++; $display("FAIL midload_reset got cnt %0d pc %h instr %h ipc %h exp 0 0 0 0", bus.load_count, bus.pc, bus.instr, bus.instr_pc); end
    tests++; if ({bus.instr_valid, bus.load_full, bus.halted, bus.trap} !== 4'b0) begin fails++; $display("FAIL midload_flags got %b exp 0000", {bus.instr_valid, bus.load_full, bus.halted, bus.trap}); end
    rst = 1; bus.load_en = 0; step();
    tests++; if (bus.load_count !== 6'd0) begin fails++; $display("FAIL midload_idle got cnt %0d exp 0", bus.load_count); end
    bus.load_valid = 0;
  endtask

  task automatic test_pc_wrap();
    bus.run = 1; step();
    bus.redirect = 1; bus.redirect_pc = 32'h7C; step();
    bus.redirect = 0; step();
    tests++; if (bus.instr_pc !== 32'h7C || bus.pc !== 32'h80) begin fails++; $display("FAIL wrap_7c got ipc %h pc %h exp 7c 80", bus.instr_pc, bus.pc); end
    step();
    tests++; if (bus.instr_pc !== 32'h80 || bus.instr !== prog2[0] || bus.pc !== 32'h84) begin fails++; $display("FAIL wrap_80 got ipc %h instr %h pc %h exp 80 %h 84", bus.instr_pc, bus.instr, bus.pc, prog2[0]); end
    bus.run = 0; step();
  endtask

  task automatic test_load_full();
    b8.load_en = 1; step();
    b8.load_valid = 1;
    for (int i = 0; i < 10; i++) begin
      b8.load_data = 32'hA000_0000 + 32'(i);
      step();
      if (i == 7) begin
        tests++; if (b8.load_count !== 4'd8 || b8.load_full !== 1'b1) begin fails++; $display("FAIL full_at8 got cnt %0d full %b exp 8 1", b8.load_count, b8.load_full); end
      end
    end
    tests++; if (b8.load_count !== 4'd8 || b8.load_full !== 1'b1) begin fails++; $display("FAIL full_sat got cnt %0d full %b exp 8 1", b8.load_count, b8.load_full); end
    b8.load_valid = 0; b8.load_en = 0; step();
    b8.run = 1; step();
    step();
    tests++; if (b8.instr !== 32'hA000_0000 || b8.instr_pc !== 32'h0) begin fails++; $display("FAIL full_mem0 got %h ipc %h exp a0000000 0", b8.instr, b8.instr_pc); end
    b8.redirect = 1; b8.redirect_pc = 32'h1C; step();
    b8.redirect = 0; step();
    tests++; if (b8.instr !== 32'hA000_0007 || b8.instr_pc !== 32'h1C) begin fails++; $display("FAIL full_mem7 got %h ipc %h exp a0000007 1c", b8.instr, b8.instr_pc); end
    step();
    tests++; if (b8.instr !== 32'hA000_0000 || b8.instr_pc !== 32'h20) begin fails++; $display("FAIL full_wrap8 got %h ipc %h exp a0000000 20", b8.instr, b8.instr_pc); end
    b8.run = 0; step();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_stall_redirect();
    test_misaligned();
    test_reset_mid_load();
    test_pc_wrap();
    test_load_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch and program-load unit for the RV32I core. It owns the instruction memory, the program counter and a load/run/halt state machine. It replaces the free-running counter and instruction RAM pair: adds sequential program loading, stall, branch/jump redirect with squash, misalignment trap and EBREAK halt. Decode, register file and ALU consume its registered `instr`/`instr_pc` outputs.

## Interface
- `XLEN`, 32: instruction/data/PC width.
- `DEPTH`, 32: instruction memory words, power of 2, ≥2; `AW = $clog2(DEPTH)`.
- `RESET_PC`, 0: PC value after reset and on load entry; must be 4-byte aligned.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `load_en` in 1: request/remain in program-load mode.
- `load_valid` in 1: `load_data` valid this cycle (LOAD only).
- `load_data` in XLEN: instruction word to write.
- `run` in 1: request/remain in execute mode.
- `stall` in 1: hold fetch pipeline (RUN only).
- `redirect` in 1: taken branch/JAL/JALR this cycle.
- `redirect_pc` in XLEN: redirect target.
- `pc` out XLEN: address fetched next.
- `instr` out XLEN: fetched instruction (registered).
- `instr_pc` out XLEN: address of `instr`.
- `instr_valid` out 1: `instr` is live for decode.
- `load_count` out AW+1: words written in current load.
- `load_full` out 1: memory filled (`load_count == DEPTH`).
- `halted` out 1: state is HALT.
- `trap` out 1: halt caused by misaligned redirect.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset → IDLE.
- IDLE: `load_en`=1 → LOAD (priority over `run`); else `run`=1 → RUN; else stay.
- LOAD entry clears `load_count`, `load_full`, `trap`, `instr_valid`; sets `pc` = RESET_PC.
- LOAD: `load_valid`=1 and not full → `mem[load_count[AW-1:0]]` ← `load_data`, `load_count`+1. Writes when full are ignored. `load_en`=0 → IDLE. Reaching `load_count`=DEPTH sets `load_full`, stays in LOAD until `load_en` drops.
- RUN, no stall, no redirect: `instr` ← `mem[pc[AW+1:2]]`, `instr_pc` ← `pc`, `instr_valid` ← 1, `pc` ← `pc`+4 (XLEN wrap; memory index wraps modulo DEPTH).
- RUN, `stall`=1, no redirect: `pc`, `instr`, `instr_pc`, `instr_valid` held.
- RUN, `redirect`=1 (overrides `stall`): `instr_valid` ← 0 (squash). If `redirect_pc[1:0]`≠0, → HALT with `trap` ← 1 and `pc` unchanged; else `pc` ← `redirect_pc`.
- EBREAK: when `instr_valid`=1 and `instr`==32'h00100073 and not stalled/redirected, → HALT next edge. `instr_valid` ← 0, `pc` held.
- RUN, `run`=0: → IDLE. `pc` held, `instr_valid` ← 0. Re-entering RUN resumes at held `pc`.
- HALT: `halted`=1; outputs frozen except `instr_valid`=0. Only `load_en`=1 (→ LOAD) or reset exits. `run` is ignored.
- Memory contents are not reset and survive reset. Read of an unwritten word returns X in simulation.

## Timing
- Reset values: `pc`=RESET_PC; `instr`, `instr_pc`, `load_count`=0; `instr_valid`, `load_full`, `halted`, `trap`=0.
- Reset mid-operation wins over every other input on that edge. A partial load is abandoned; `load_count`=0.
- Fetch latency 1 cycle: `pc`=A sampled at edge t gives `instr`=mem[A], `instr_pc`=A, `instr_valid`=1 after edge t.
- Redirect at edge t: bubble (`instr_valid`=0) after t. Target instruction is valid after t+1.
- Load write is visible to a RUN fetch on the cycle after LOAD exits.
- State-change outputs (`halted`, `trap`, `load_full`) update on the same edge as the state register.

## Test plan
- Reset, load 4 words {0x00000013, 0x00100093, 0x00200113, 0x00100073}, drop `load_en`, assert `run`. Required: `instr_pc` 0,4,8,12 on consecutive cycles. `halted`=1 one cycle after 0x00100073 is valid; `trap`=0.
- DEPTH=8: stream 10 words. Required: `load_count` saturates at 8, `load_full`=1, words 9–10 are not written (mem[0] retains first word).
- RUN with `stall`=1 for 3 cycles at `pc`=0x8. Required: `pc`, `instr`, `instr_pc`, `instr_valid` constant. Resume gives `instr_pc`=0x8, then 0xC.
- `redirect`=1, `redirect_pc`=0x10, same cycle `stall`=1. Required: next cycle `instr_valid`=0, following cycle `instr_pc`=0x10.
- `redirect_pc`=0x6. Required: `halted`=1, `trap`=1, `pc` unchanged. `run` is ignored; `load_en` re-enters LOAD with `trap`=0 and `pc`=RESET_PC.
- Assert `rst`=0 mid-load after 3 words. Required: all outputs at reset values next cycle, state IDLE, `load_count`=0. PC wraps from 0x7C to 0x80, fetching index 0 when DEPTH=32.
